// File: rtl/mult_pkg.sv
// Shared types and sizes for the repeated-addition multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg

// File: rtl/add.sv
// Purpose: 16-bit combinational adder used beside the multiplier controller.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output always reflects the current inputs.
// Ports: in1, in2 - addends; out - sum modulo 2^16 (no carry-out).
module ADD (
  output logic [15:0] out,
  input  logic [15:0] in1,
  input  logic [15:0] in2
);

  assign out = in1 + in2;

endmodule : ADD

// File: rtl/rep_add_mult_ctrl.sv
// Purpose: unsigned 8x8 multiply by repeated addition through an external 16-bit adder.
// Latency: done is high min(op_a,op_b)+1 cycles after the start-accept edge.
// Backpressure: start is honoured only while busy=0; requests while busy are dropped.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start, op_a, op_b - request and operands, captured together when idle
//   add_in1, add_in2  - adder operands (accumulator, addend)
//   add_out           - adder sum fed back into the accumulator
//   busy, done        - controller status; done is a one-cycle pulse
//   product           - last completed result, held until the next completion
module rep_add_mult_ctrl
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [PW-1:0]    add_in1,
  output logic [PW-1:0]    add_in2,
  input  logic [PW-1:0]    add_out,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    product
);

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    addend_q, addend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;

  // Looping over the smaller operand bounds the worst case to 255 additions.
  logic             a_ge_b;
  logic [WIDTH-1:0] op_max, op_min;

  assign a_ge_b = (op_a >= op_b);
  assign op_max = a_ge_b ? op_a : op_b;
  assign op_min = a_ge_b ? op_b : op_a;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    addend_d  = addend_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addend_d = {{(PW-WIDTH){1'b0}}, op_max};
          cnt_d    = op_min;
          acc_d    = '0;
          if (op_min != '0) begin
            state_d = RUN;
          end else begin
            // Zero operand: nothing to iterate, complete straight away.
            state_d   = DONE;
            product_d = '0;
          end
        end
      end
      RUN: begin
        acc_d = add_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
          // Last addition: the adder output already holds the full product.
          state_d   = DONE;
          product_d = add_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      addend_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      addend_q  <= addend_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign add_in1 = acc_q;
  assign add_in2 = addend_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule : rep_add_mult_ctrl

// File: tb/tb_rep_add_mult_ctrl.sv
// Bench for rep_add_mult_ctrl wired to the ADD adder.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_rep_add_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic [15:0] add_in1, add_in2, add_out;
  logic        busy, done;
  logic [15:0] product;

  ADD u_add (
    .out (add_out),
    .in1 (add_in1),
    .in2 (add_in2)
  );

  rep_add_mult_ctrl u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .add_in1 (add_in1),
    .add_in2 (add_in2),
    .add_out (add_out),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Scoreboard entry: expected product and the cycle in which done must show.
  typedef struct {
    logic [15:0] prod;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: each done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", {16'd0, product}, {16'd0, e.prod});
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;
  vec_t vecs[10];

  function automatic int min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? int'(a) : int'(b);
  endfunction

  // Drive a one-cycle start; returns at the negedge of cycle 1 after accept.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("issue_timeout", 32'd1, 32'd0);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sb.push_back('{prod: prod, done_cyc: cyc + 1 + min8(a, b)});
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom_range(0, 255);
    op_b  = $urandom_range(0, 255);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0 || busy) begin
      chk("wait_idle_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{a: 8'd5,   b: 8'd3,   prod: 16'd15};
    vecs[1] = '{a: 8'd255, b: 8'd255, prod: 16'd65025};
    vecs[2] = '{a: 8'd0,   b: 8'd200, prod: 16'd0};
    vecs[3] = '{a: 8'd1,   b: 8'd1,   prod: 16'd1};
    vecs[4] = '{a: 8'd200, b: 8'd0,   prod: 16'd0};
    vecs[5] = '{a: 8'd3,   b: 8'd5,   prod: 16'd15};
    vecs[6] = '{a: 8'd16,  b: 8'd17,  prod: 16'd272};
    vecs[7] = '{a: 8'd255, b: 8'd1,   prod: 16'd255};
    vecs[8] = '{a: 8'd128, b: 8'd2,   prod: 16'd256};
    vecs[9] = '{a: 8'd100, b: 8'd37,  prod: 16'd3700};

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 8'd0;
    op_b  = 8'd0;
    repeat (3) @(negedge clk);

    // Reset state, all outputs X-free.
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_add_in1", {16'd0, add_in1}, 32'd0);
    chk("rst_add_in2", {16'd0, add_in2}, 32'd0);
    rst_n = 1'b1;

    // Table of single jobs.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].prod);
      wait_idle();
    end

    // 5x3: busy high in cycles 1..4 after accept, low in cycle 5.
    issue(8'd5, 8'd3, 16'd15);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wait_idle();

    // 4x6 with a 9x9 start asserted during RUN: it must be dropped.
    issue(8'd4, 8'd6, 16'd24);
    start = 1'b1;
    op_a  = 8'd9;
    op_b  = 8'd9;
    @(negedge clk);
    chk("busy_run_ignore", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("product_hold_24", {16'd0, product}, 32'd24);

    // 10x10 aborted by reset in RUN cycle 3.
    issue(8'd10, 8'd10, 16'd100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_busy",    {31'd0, busy}, 32'd0);
    chk("abort_done",    {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;
    issue(8'd7, 8'd6, 16'd42);
    wait_idle();

    // Back-to-back with start held: 12x11 then 3x2.
    begin
      int guard;
      int d;
      @(negedge clk);
      start = 1'b1;
      op_a  = 8'd12;
      op_b  = 8'd11;
      sb.push_back('{prod: 16'd132, done_cyc: cyc + 1 + 11});
      @(negedge clk);
      guard = 0;
      while (!done && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!done) chk("b2b_timeout", 32'd1, 32'd0);
      d    = cyc;
      op_a = 8'd3;
      op_b = 8'd2;
      // DONE->IDLE edge ignores start; the following edge accepts.
      sb.push_back('{prod: 16'd6, done_cyc: d + 2 + 2});
      @(negedge clk);
      chk("b2b_hold_1", {16'd0, product}, 32'd132);
      chk("b2b_idle",   {31'd0, busy}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_hold_2", {16'd0, product}, 32'd132);
      chk("b2b_busy2",  {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("b2b_hold_3", {16'd0, product}, 32'd132);
      wait_idle();
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_rep_add_mult_ctrl
